bullet_slot_arbiter: RTL and testbench
======================================

BULLET_SLOT_ARBITER -- requirements
Module: bullet_slot_arbiter

Interface
REQ-001 Parameter: NUM_REQ, default 4, number of bullet requesters; index 0 is the player, 1..NUM_REQ-1 are enemies.
REQ-002 Parameter: NUM_SLOTS, default 4, number of shared on-screen bullet slots.
REQ-003 frame_clk  in  1  sole clock; all state updates on its rising edge.
REQ-004 Reset_n  in  1  asynchronous, active-low reset.
REQ-005 game  in  1  game-phase enable from the game state machine; 0 means start, win or lose screen.
REQ-006 req  in  NUM_REQ  per-requester fire request; level, held until granted.
REQ-007 release  in  NUM_SLOTS  per-slot free pulse (bullet hit or left the screen).
REQ-008 gnt  out  NUM_REQ  one-hot grant, registered, one cycle wide.
REQ-009 gnt_slot  out  $clog2(NUM_SLOTS)  slot index bound to the current grant; valid only while |gnt is 1.
REQ-010 slot_busy  out  NUM_SLOTS  registered occupancy vector.
REQ-011 busy_count  out  $clog2(NUM_SLOTS)+1  number of set bits in slot_busy.
REQ-012 deny_count  out  8  saturating count of cycles in which a request was starved for lack of a free slot.

Function
REQ-013 Eligible requests: req & ~gnt. A requester is masked during the cycle its grant is high.
REQ-014 Decision is combinational from the registered state. Its result is registered at the edge, so a grant is visible one cycle after the request is sampled.
REQ-015 At most one grant per cycle.
REQ-016 A grant occurs iff game=1, at least one eligible request exists, and at least one slot is free in the registered slot_busy.
REQ-017 Slot choice: the lowest-index free slot.
REQ-018 Requester choice: round-robin, searching upward from (last_gnt+1) mod NUM_REQ.
REQ-019 last_gnt updates only on a grant.
REQ-020 On a grant edge: set slot_busy[slot], drive gnt[i]=1 for one cycle, and drive gnt_slot=slot.
REQ-021 On a release[k] edge: clear slot_busy[k]; the slot becomes grantable from the next cycle.
REQ-022 Release of a non-busy slot is ignored.
REQ-023 A slot released in cycle n cannot be granted in cycle n; it becomes grantable in cycle n+1.
REQ-024 deny_count increments when game=1, an eligible request exists, and all slots are busy.
REQ-025 deny_count saturates at 255.
REQ-026 While game=0: gnt=0; slot_busy, last_gnt and busy_count clear at the next edge; deny_count holds.
REQ-027 game rising to 1 clears deny_count at that edge.
REQ-028 busy_count equals popcount(slot_busy) in every cycle.

Reset
REQ-029 While Reset_n=0: gnt=0, gnt_slot=0, slot_busy=0, busy_count=0, deny_count=0, last_gnt=NUM_REQ-1, so the first round-robin search starts at requester 0.
REQ-030 Reset asserted mid-grant drops gnt immediately, without waiting for a clock edge.
REQ-031 The first grant can occur at the second rising edge after Reset_n deasserts.

Configuration
REQ-032 Macro: BULLET_PLAYER_PRIORITY_EN.
REQ-033 Macro defined: an eligible req[0] always wins, and last_gnt is not updated by player grants. Enemies rotate among themselves.
REQ-034 Macro undefined: pure round-robin over all requesters, per REQ-018.

Structure
REQ-035 Package bullet_pkg holds NUM_REQ and NUM_SLOTS defaults, SLOT_W, CNT_W, the constant REQ_PLAYER=0, and DENY_MAX=255.
REQ-036 Sub-module rr_pick is a purely combinational round-robin one-hot picker with inputs request vector and last index, and outputs one-hot and valid. It is instantiated once.
REQ-037 Slot selection and popcount are coded inline.

Verification
REQ-038 Reset, then game=1 and req=4'b0001 held: gnt=0001 and gnt_slot=0 in cycle 2; slot_busy=0001; busy_count=1.
REQ-039 req=4'b1111 held, no releases: grants go 0,1,2,3 in consecutive cycles with slots 0,1,2,3. Then all slots are busy, gnt stays 0, and deny_count increments each cycle.
REQ-040 All slots busy, release=0100 in cycle n with req[1] pending: no grant in cycle n; gnt=0010 with gnt_slot=2 at the edge ending cycle n+1.
REQ-041 Four grants issued, then game dropped to 0 for one edge: slot_busy=0 and gnt=0. game back to 1: deny_count=0, and round-robin restarts at requester 0.
REQ-042 BULLET_PLAYER_PRIORITY_EN defined and req=1111 continuously with a release every cycle: the player is granted whenever eligible, and enemies 1,2,3 alternate in order in the remaining grants.
REQ-043 Reset_n pulsed low mid-operation with gnt=0100: gnt drops to 0 during reset, before the next edge, and all outputs read their REQ-029 values.

Source files
------------

// File: rtl/bullet_pkg.sv
// Shared constants for the bullet slot arbiter.
//
// Contents:
//   DEF_NUM_REQ / DEF_NUM_SLOTS  default requester and slot counts
//   REQ_PLAYER                   requester index that belongs to the player
//   DENY_MAX                     saturation value of the starvation counter
//   SLOT_W / CNT_W               slot-index and occupancy-count widths for the defaults
//   idx_width()                  index width helper that never returns zero
package bullet_pkg;

    localparam int DEF_NUM_REQ   = 4;
    localparam int DEF_NUM_SLOTS = 4;
    localparam int REQ_PLAYER    = 0;
    localparam int DENY_MAX      = 255;

    // A single-entry vector still needs a one-bit index port.
    function automatic int idx_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

    localparam int SLOT_W = idx_width(DEF_NUM_SLOTS);
    localparam int CNT_W  = SLOT_W + 1;

endpackage

// File: rtl/bullet_slot_arbiter_rr_pick.sv
// rr_pick: combinational round-robin one-hot picker.
//
// Ports:
//   request  in   N       candidate vector
//   last     in   IDX_W   index granted last time; search starts just above it
//   onehot   out  N       selected requester, one-hot (zero when none)
//   valid    out  1       at least one request was selected
module rr_pick #(
    parameter int N     = 4,
    parameter int IDX_W = 2
) (
    input  logic [N-1:0]     request,
    input  logic [IDX_W-1:0] last,
    output logic [N-1:0]     onehot,
    output logic             valid
);

    logic [IDX_W-1:0] pos;

    // Walk the N positions starting at last+1, wrapping, and keep the first hit.
    always_comb begin
        onehot = '0;
        valid  = 1'b0;
        pos    = '0;
        for (int k = 1; k <= N; k++) begin
            pos = IDX_W'((int'(last) + k) % N);
            if (!valid && request[pos]) begin
                onehot[pos] = 1'b1;
                valid       = 1'b1;
            end
        end
    end

endmodule

// File: rtl/bullet_slot_arbiter.sv
// bullet_slot_arbiter: hands out shared on-screen bullet slots to the player
// and enemies, one grant per frame clock, round-robin over requesters and
// lowest-free-slot placement.
//
// Ports:
//   frame_clk     in   1            clock
//   Reset_n       in   1            asynchronous active-low reset
//   game          in   1            game phase active; 0 on start/win/lose screens
//   req           in   NUM_REQ      fire requests (held until granted), 0 = player
//   slot_release  in   NUM_SLOTS    per-slot free pulse ("release" is a reserved word)
//   gnt           out  NUM_REQ      one-hot registered grant, one cycle wide
//   gnt_slot      out  SLOT index   slot bound to the current grant
//   slot_busy     out  NUM_SLOTS    registered slot occupancy
//   busy_count    out  SLOT idx+1   popcount of slot_busy
//   deny_count    out  8            saturating count of slot-starved cycles
//
// Build option: define BULLET_PLAYER_PRIORITY_EN to let an eligible player
// request always win; enemies then rotate among themselves.
module bullet_slot_arbiter
    import bullet_pkg::*;
#(
    parameter int NUM_REQ   = DEF_NUM_REQ,
    parameter int NUM_SLOTS = DEF_NUM_SLOTS
) (
    input  logic                             frame_clk,
    input  logic                             Reset_n,
    input  logic                             game,
    input  logic [NUM_REQ-1:0]               req,
    input  logic [NUM_SLOTS-1:0]             slot_release,
    output logic [NUM_REQ-1:0]               gnt,
    output logic [idx_width(NUM_SLOTS)-1:0]  gnt_slot,
    output logic [NUM_SLOTS-1:0]             slot_busy,
    output logic [idx_width(NUM_SLOTS):0]    busy_count,
    output logic [7:0]                       deny_count
);

    localparam int RW = idx_width(NUM_REQ);
    localparam int SW = idx_width(NUM_SLOTS);

    logic [NUM_REQ-1:0]   eligible;
    logic [NUM_REQ-1:0]   pick_req;
    logic [NUM_REQ-1:0]   pick_onehot;
    logic                 pick_valid;
    logic [NUM_REQ-1:0]   choice;
    logic [RW-1:0]        choice_idx;
    logic                 have_choice;
    logic                 update_last;
    logic [RW-1:0]        last_gnt;
    logic [SW-1:0]        free_slot;
    logic                 slot_free;
    logic [NUM_SLOTS-1:0] slot_bit;
    logic                 grant_now;
    logic                 deny_now;
    logic                 game_q;
    // Low for the first edge after reset so a grant is never registered
    // on that edge.
    logic                 armed;

    // A requester whose grant is currently showing is not a candidate again.
    assign eligible = req & ~gnt;

    rr_pick #(
        .N     (NUM_REQ),
        .IDX_W (RW)
    ) u_rr_pick (
        .request (pick_req),
        .last    (last_gnt),
        .onehot  (pick_onehot),
        .valid   (pick_valid)
    );

    always_comb begin
        choice      = pick_onehot;
        have_choice = pick_valid;
        update_last = 1'b1;
        pick_req    = eligible;
`ifdef BULLET_PLAYER_PRIORITY_EN
        // The player is removed from rotation; enemies rotate around last_gnt,
        // which only ever holds an enemy index after a grant.
        pick_req[REQ_PLAYER] = 1'b0;
        if (eligible[REQ_PLAYER]) begin
            choice             = '0;
            choice[REQ_PLAYER] = 1'b1;
            update_last        = 1'b0;
        end
        have_choice = pick_valid | eligible[REQ_PLAYER];
`endif
    end

    always_comb begin
        choice_idx = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (choice[i]) choice_idx = RW'(i);
        end
    end

    // Downward scan so the last assignment is the lowest free slot.
    always_comb begin
        free_slot = '0;
        slot_free = 1'b0;
        for (int i = NUM_SLOTS - 1; i >= 0; i--) begin
            if (!slot_busy[i]) begin
                free_slot = SW'(i);
                slot_free = 1'b1;
            end
        end
        slot_bit            = '0;
        slot_bit[free_slot] = 1'b1;
    end

    always_comb begin
        busy_count = '0;
        for (int i = 0; i < NUM_SLOTS; i++) begin
            busy_count = busy_count + (SW + 1)'(slot_busy[i]);
        end
    end

    assign grant_now = game & armed & have_choice & slot_free;
    assign deny_now  = game & armed & (|eligible) & ~slot_free;

    // Releases act on the registered occupancy, so a freed slot is only seen
    // by the decision logic one cycle later.
    always_ff @(posedge frame_clk or negedge Reset_n) begin
        if (!Reset_n) begin
            gnt        <= '0;
            gnt_slot   <= '0;
            slot_busy  <= '0;
            deny_count <= '0;
            last_gnt   <= RW'(NUM_REQ - 1);
            game_q     <= 1'b0;
            armed      <= 1'b0;
        end else begin
            armed  <= 1'b1;
            game_q <= game;
            if (!game) begin
                gnt       <= '0;
                gnt_slot  <= '0;
                slot_busy <= '0;
                last_gnt  <= RW'(NUM_REQ - 1);
            end else begin
                gnt       <= grant_now ? choice : '0;
                gnt_slot  <= grant_now ? free_slot : '0;
                slot_busy <= (slot_busy & ~slot_release) | (grant_now ? slot_bit : '0);
                if (grant_now && update_last) begin
                    last_gnt <= choice_idx;
                end
                if (!game_q) begin
                    deny_count <= '0;
                end else if (deny_now && deny_count != 8'(DENY_MAX)) begin
                    deny_count <= deny_count + 8'd1;
                end
            end
        end
    end

endmodule

// File: tb/tb_bullet_slot_arbiter.sv
// Testbench for bullet_slot_arbiter: directed vectors with literal
// expectations plus a cycle-by-cycle comparison against a behavioural model.
module tb_bullet_slot_arbiter;
    import bullet_pkg::*;

    localparam int NREQ  = DEF_NUM_REQ;
    localparam int NSLOT = DEF_NUM_SLOTS;

    logic              frame_clk;
    logic              Reset_n;
    logic              game;
    logic [NREQ-1:0]   req;
    logic [NSLOT-1:0]  slot_release;
    logic [NREQ-1:0]   gnt;
    logic [SLOT_W-1:0] gnt_slot;
    logic [NSLOT-1:0]  slot_busy;
    logic [CNT_W-1:0]  busy_count;
    logic [7:0]        deny_count;

    int total = 0;
    int bad   = 0;

    // Behavioural model state: which slots hold a bullet, who fired last,
    // who is being granted now (-1 none), and frame bookkeeping.
    bit mBusy[NSLOT];
    int mLast;
    int mGnt;
    int mSlot;
    int mDeny;
    bit mGamePrev;
    int mEdges;

    bullet_slot_arbiter dut (
        .frame_clk    (frame_clk),
        .Reset_n      (Reset_n),
        .game         (game),
        .req          (req),
        .slot_release (slot_release),
        .gnt          (gnt),
        .gnt_slot     (gnt_slot),
        .slot_busy    (slot_busy),
        .busy_count   (busy_count),
        .deny_count   (deny_count)
    );

    initial frame_clk = 1'b0;
    always #5 frame_clk = ~frame_clk;

    task automatic checkOutput(input string name, input int actual, input int expected);
        total++;
        if (actual !== expected) begin
            bad++;
            $display("[TB] FAIL %s: got %0h expected %0h at %0t", name, actual, expected, $time);
        end
    endtask

    task automatic applyStimulus(input bit g, input logic [NREQ-1:0] r, input logic [NSLOT-1:0] rl);
        @(negedge frame_clk);
        game         = g;
        req          = r;
        slot_release = rl;
    endtask

    task automatic tick();
        @(posedge frame_clk);
        #2;
    endtask

    // One frame of the game rules: who may fire, who wins, where the bullet goes.
    task automatic modelStep();
        bit elig[NREQ];
        int nElig;
        int nFree;
        int pick;
        int slot;
        int idx;
        if (!Reset_n) begin
            foreach (mBusy[s]) mBusy[s] = 1'b0;
            mLast = NREQ - 1;
            mGnt = -1;
            mSlot = 0;
            mDeny = 0;
            mGamePrev = 1'b0;
            mEdges = 0;
            return;
        end
        nElig = 0;
        for (int i = 0; i < NREQ; i++) begin
            elig[i] = req[i] && (mGnt != i);
            if (elig[i]) nElig++;
        end
        nFree = 0;
        foreach (mBusy[s]) if (!mBusy[s]) nFree++;
        pick = -1;
        slot = -1;
        if (game && mEdges >= 1 && nElig > 0 && nFree > 0) begin
`ifdef BULLET_PLAYER_PRIORITY_EN
            if (elig[0]) pick = 0;
            for (int k = 1; k <= NREQ; k++) begin
                idx = (mLast + k) % NREQ;
                if (pick < 0 && idx != 0 && elig[idx]) pick = idx;
            end
`else
            for (int k = 1; k <= NREQ; k++) begin
                idx = (mLast + k) % NREQ;
                if (pick < 0 && elig[idx]) pick = idx;
            end
`endif
            for (int s = NSLOT - 1; s >= 0; s--) if (!mBusy[s]) slot = s;
        end
        if (!game) begin
            foreach (mBusy[s]) mBusy[s] = 1'b0;
            mLast = NREQ - 1;
            mGnt = -1;
            mSlot = 0;
        end else begin
            if (!mGamePrev) mDeny = 0;
            else if (nElig > 0 && nFree == 0 && mDeny < 255) mDeny++;
            foreach (mBusy[s]) if (slot_release[s]) mBusy[s] = 1'b0;
            mGnt = pick;
            mSlot = (pick >= 0) ? slot : 0;
            if (pick >= 0) begin
                mBusy[slot] = 1'b1;
`ifdef BULLET_PLAYER_PRIORITY_EN
                if (pick != 0) mLast = pick;
`else
                mLast = pick;
`endif
            end
        end
        mGamePrev = game;
        mEdges++;
    endtask

    // Compare process: advance the model at every edge and check all outputs.
    initial begin
        int expBusy;
        int expCount;
        forever begin
            @(posedge frame_clk);
            modelStep();
            #1;
            expBusy = 0;
            expCount = 0;
            foreach (mBusy[s]) begin
                if (mBusy[s]) begin
                    expBusy += (1 << s);
                    expCount++;
                end
            end
            checkOutput("model_gnt", int'(gnt), (mGnt < 0) ? 0 : (1 << mGnt));
            if (mGnt >= 0) checkOutput("model_gnt_slot", int'(gnt_slot), mSlot);
            checkOutput("model_slot_busy", int'(slot_busy), expBusy);
            checkOutput("model_busy_count", int'(busy_count), expCount);
            checkOutput("model_deny_count", int'(deny_count), mDeny);
        end
    end

    // Directed sequence with hand-computed expectations.
    initial begin
        logic [NREQ-1:0] seqGnt[8];
        logic [15:0] table16[16];
        Reset_n = 1'b0;
        game = 1'b0;
        req = '0;
        slot_release = '0;
        repeat (2) @(posedge frame_clk);
        #2;
        checkOutput("reset_gnt", int'(gnt), 0);
        checkOutput("reset_gnt_slot", int'(gnt_slot), 0);
        checkOutput("reset_slot_busy", int'(slot_busy), 0);
        checkOutput("reset_busy_count", int'(busy_count), 0);
        checkOutput("reset_deny_count", int'(deny_count), 0);

`ifdef BULLET_PLAYER_PRIORITY_EN
        seqGnt = '{4'b0001, 4'b0010, 4'b0001, 4'b0100, 4'b0001, 4'b1000, 4'b0001, 4'b0010};
        applyStimulus(1'b1, 4'b1111, 4'b1111);
        Reset_n = 1'b1;
        tick();
        checkOutput("prio_first_edge_gnt", int'(gnt), 0);
        for (int i = 0; i < 8; i++) begin
            tick();
            checkOutput("prio_grant_order", int'(gnt), int'(seqGnt[i]));
        end
`else
        seqGnt = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0, 4'b0, 4'b0, 4'b0};
        applyStimulus(1'b1, 4'b0001, 4'b0000);
        Reset_n = 1'b1;
        tick();
        checkOutput("first_edge_gnt", int'(gnt), 0);
        tick();
        checkOutput("first_grant_gnt", int'(gnt), 1);
        checkOutput("first_grant_slot", int'(gnt_slot), 0);
        checkOutput("first_grant_busy", int'(slot_busy), 1);
        checkOutput("first_grant_count", int'(busy_count), 1);

        applyStimulus(1'b0, 4'b0000, 4'b0000);
        tick();
        checkOutput("game_off_busy", int'(slot_busy), 0);

        applyStimulus(1'b1, 4'b1111, 4'b0000);
        for (int i = 0; i < 4; i++) begin
            tick();
            checkOutput("rr_gnt", int'(gnt), int'(seqGnt[i]));
            checkOutput("rr_slot", int'(gnt_slot), i);
        end
        checkOutput("full_count", int'(busy_count), 4);
        for (int i = 1; i <= 3; i++) begin
            tick();
            checkOutput("full_gnt", int'(gnt), 0);
            checkOutput("full_deny", int'(deny_count), i);
        end

        applyStimulus(1'b1, 4'b0010, 4'b0100);
        tick();
        checkOutput("release_same_cycle_gnt", int'(gnt), 0);
        checkOutput("release_busy", int'(slot_busy), 4'b1011);
        checkOutput("release_deny", int'(deny_count), 4);
        applyStimulus(1'b1, 4'b0010, 4'b0000);
        tick();
        checkOutput("release_next_gnt", int'(gnt), 4'b0010);
        checkOutput("release_next_slot", int'(gnt_slot), 2);

        applyStimulus(1'b0, 4'b0000, 4'b0000);
        tick();
        checkOutput("game_drop_busy", int'(slot_busy), 0);
        checkOutput("game_drop_deny_hold", int'(deny_count), 4);

        applyStimulus(1'b1, 4'b1111, 4'b1000);
        tick();
        checkOutput("game_rise_deny", int'(deny_count), 0);
        checkOutput("restart_gnt", int'(gnt), 4'b0001);
        checkOutput("idle_release_busy", int'(slot_busy), 4'b0001);
        applyStimulus(1'b1, 4'b1111, 4'b0000);
        tick();
        checkOutput("restart_gnt2", int'(gnt), 4'b0010);
        tick();
        checkOutput("pre_reset_gnt", int'(gnt), 4'b0100);

        Reset_n = 1'b0;
        #1;
        checkOutput("async_reset_gnt", int'(gnt), 0);
        checkOutput("async_reset_slot", int'(gnt_slot), 0);
        checkOutput("async_reset_busy", int'(slot_busy), 0);
        checkOutput("async_reset_count", int'(busy_count), 0);
`endif

        // Mixed traffic checked only by the model: {game, req, release}.
        table16 = '{16'h1_F_0, 16'h1_F_0, 16'h1_F_0, 16'h1_F_0, 16'h1_F_0, 16'h1_E_1,
                    16'h1_6_8, 16'h1_9_6, 16'h1_F_F, 16'h1_3_0, 16'h0_F_0, 16'h1_F_0,
                    16'h1_A_2, 16'h1_5_4, 16'h1_F_9, 16'h1_1_0};
        applyStimulus(1'b0, 4'b0000, 4'b0000);
        Reset_n = 1'b0;
        tick();
        applyStimulus(1'b0, 4'b0000, 4'b0000);
        Reset_n = 1'b1;
        foreach (table16[i]) begin
            applyStimulus(table16[i][8], table16[i][7:4], table16[i][3:0]);
        end
        applyStimulus(1'b1, 4'b0000, 4'b0000);
        repeat (2) tick();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
